// File: rtl/lib_sample_seq_if.sv
// -----------------------------------------------------------------------------
// lib_sample_seq_if
//
// Bundles every signal between the self-test sequencer and its surroundings,
// except the clock and reset: the run request/cancel controls, the run
// configuration, the two observed counter outputs of lib_sample, the control
// outputs that drive lib_sample, and the status outputs.
//
// Modports:
//   master : the sequencer. It reads requests, configuration and observed
//            values, and drives the block controls and the status.
//   slave  : the environment (test wrapper or bench). It is the mirror image.
//
// Signals:
//   START       run request, sampled only in IDLE
//   ABORT       cancel the current run
//   RUN_LEN     run length L (0 runs as 1)
//   BYPASS_PAT  pattern expected back through the block's bypass mux
//   CNTR_IN     observed CNTR_OUT2 of lib_sample
//   MUX_IN      observed CNTR_OUT3 of lib_sample
//   DUT_RST_B   reset to lib_sample, active-low
//   SELECT_3    output mux select to lib_sample
//   EN_G        gated-clock enable to lib_sample
//   BYPASS      bypass value to lib_sample
//   BUSY        sequence in progress
//   DONE        one-cycle completion pulse
//   PASS        result of the last completed run
//   ERR_CODE    bit0 count mismatch, bit1 bypass mismatch
// -----------------------------------------------------------------------------
interface lib_sample_seq_if #(
  parameter int WIDTH = 3,
  parameter int RUN_W = 8
);

  logic             START;
  logic             ABORT;
  logic [RUN_W-1:0] RUN_LEN;
  logic [WIDTH-1:0] BYPASS_PAT;
  logic [WIDTH-1:0] CNTR_IN;
  logic [WIDTH-1:0] MUX_IN;

  logic             DUT_RST_B;
  logic             SELECT_3;
  logic             EN_G;
  logic [WIDTH-1:0] BYPASS;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [1:0]       ERR_CODE;

  modport master (
    input  START, ABORT, RUN_LEN, BYPASS_PAT, CNTR_IN, MUX_IN,
    output DUT_RST_B, SELECT_3, EN_G, BYPASS, BUSY, DONE, PASS, ERR_CODE
  );

  modport slave (
    output START, ABORT, RUN_LEN, BYPASS_PAT, CNTR_IN, MUX_IN,
    input  DUT_RST_B, SELECT_3, EN_G, BYPASS, BUSY, DONE, PASS, ERR_CODE
  );

endinterface : lib_sample_seq_if

// File: rtl/lib_sample_seq.sv
// -----------------------------------------------------------------------------
// lib_sample_seq
//
// Self-test sequencer for the lib_sample counter/divider block. On an accepted
// START it holds the block in reset for RST_CYCLES cycles, lets it count for
// L cycles with the gated clock enabled, checks the counter value (L modulo
// 2^WIDTH), then switches the block's output mux to bypass and checks that the
// captured pattern comes back. The result is reported with a one-cycle DONE,
// a PASS flag and a two-bit ERR_CODE.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_B  asynchronous active-low reset
//   bus    lib_sample_seq_if.master (requests, configuration, observed
//          counter values, block controls and status)
//
// Every output comes straight from a flop. The flops are loaded from a decode
// of the next state, so each output takes its new state's value on the very
// edge that enters that state.
// -----------------------------------------------------------------------------
module lib_sample_seq #(
  parameter int WIDTH      = 3,
  parameter int RUN_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  lib_sample_seq_if.master     bus
);

  // The hold counter only has to reach RST_CYCLES-1.
  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_RST,
    S_RUN,
    S_CHECK_CNT,
    S_CHECK_BYP,
    S_FIN
  } state_e;

  // Per-state Moore controls for the block and the status flags.
  typedef struct packed {
    logic dut_rst_b;
    logic select_3;
    logic en_g;
    logic busy;
    logic done;
  } ctl_t;

  function automatic ctl_t decode(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_HOLD_RST:  begin c.select_3 = 1'b1; c.busy = 1'b1; end
      S_RUN:       begin c.dut_rst_b = 1'b1; c.select_3 = 1'b1; c.en_g = 1'b1; c.busy = 1'b1; end
      S_CHECK_CNT: begin c.dut_rst_b = 1'b1; c.select_3 = 1'b1; c.busy = 1'b1; end
      S_CHECK_BYP: begin c.dut_rst_b = 1'b1; c.busy = 1'b1; end
      S_FIN:       c.done = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [1:0]         err_q, err_d;
  logic               pass_q, pass_d;
  ctl_t               ctl_q, ctl_d;
  logic [WIDTH-1:0]   bypass_q, bypass_d;
  logic [WIDTH-1:0]   exp_cnt;

  // The block's counter wraps, so only the low WIDTH bits of L are expected.
  assign exp_cnt = WIDTH'(len_q);

  // Next-state and result logic.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    len_d      = len_q;
    pat_d      = pat_q;
    err_d      = err_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d    = S_HOLD_RST;
          hold_cnt_d = '0;
          len_d      = (bus.RUN_LEN == '0) ? RUN_W'(1) : bus.RUN_LEN;
          pat_d      = bus.BYPASS_PAT;
          err_d      = 2'b00;
          pass_d     = 1'b0;
        end
      end

      S_HOLD_RST: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      // run_cnt tops out at L-1, so L = 2^RUN_W-1 never overflows it.
      S_RUN: begin
        if (run_cnt_q == len_q - 1'b1) begin
          state_d = S_CHECK_CNT;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end

      S_CHECK_CNT: begin
        if (bus.CNTR_IN != exp_cnt) err_d[0] = 1'b1;
        state_d = S_CHECK_BYP;
      end

      // PASS is judged from the error code as it will stand on entering FIN,
      // bypass result included.
      S_CHECK_BYP: begin
        if (bus.MUX_IN != pat_q) err_d[1] = 1'b1;
        pass_d  = (err_d == 2'b00);
        state_d = S_FIN;
      end

      S_FIN:   state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // ABORT overrides every transition above, including the FIN exit.
    if (bus.ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = 2'b00;
      pass_d  = 1'b0;
    end
  end

  // Output decode from the next state, and the bypass load on CHECK_BYP entry.
  always_comb begin
    ctl_d    = decode(state_d);
    bypass_d = bypass_q;
    if ((state_q == S_CHECK_CNT) && (state_d == S_CHECK_BYP)) bypass_d = pat_q;
  end

  // NOTE: every flop here, including configuration and counters, has a reset
  // value, so the block leaves reset fully defined without a first START.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      run_cnt_q  <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      err_q      <= 2'b00;
      pass_q     <= 1'b0;
      ctl_q      <= '0;
      bypass_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      run_cnt_q  <= run_cnt_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      ctl_q      <= ctl_d;
      bypass_q   <= bypass_d;
    end
  end

  assign bus.DUT_RST_B = ctl_q.dut_rst_b;
  assign bus.SELECT_3  = ctl_q.select_3;
  assign bus.EN_G      = ctl_q.en_g;
  assign bus.BUSY      = ctl_q.busy;
  assign bus.DONE      = ctl_q.done;
  assign bus.BYPASS    = bypass_q;
  assign bus.PASS      = pass_q;
  assign bus.ERR_CODE  = err_q;

endmodule : lib_sample_seq

// File: doc/lib_sample_seq.md
# lib_sample_seq

Self-test sequencer for the `lib_sample` counter/divider block. On a start request it:
- holds the block in reset;
- lets it count for a programmed number of cycles with the gated clock enabled;
- checks the resetable counter value;
- switches the output mux to bypass and checks the bypass pattern.

It sits beside `lib_sample` in the test wrapper, drives its control inputs and observes two of its counter outputs. Results are reported with a done pulse, a pass flag and an error code.

## Interface
Parameters:
- WIDTH, 3, width of the block's counters and bypass bus
- RUN_W, 8, width of the run-length field
- RST_CYCLES, 2, cycles the block is held in reset before a run (≥1)

Ports:
- CLK  in  1  system clock, rising edge
- RST_B  in  1  reset, asynchronous, active-low
- START  in  1  run request, sampled only in IDLE
- ABORT  in  1  cancel run, sampled in any non-IDLE state
- RUN_LEN  in  RUN_W  run length L, captured on START accept; 0 is treated as 1
- BYPASS_PAT  in  WIDTH  bypass pattern, captured on START accept
- CNTR_IN  in  WIDTH  observed CNTR_OUT2 of the block
- MUX_IN  in  WIDTH  observed CNTR_OUT3 of the block
- DUT_RST_B  out  1  reset to the block (drives its RST_B)
- SELECT_3  out  1  mux select to the block
- EN_G  out  1  gated-clock enable to the block
- BYPASS  out  WIDTH  bypass value to the block
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse
- PASS  out  1  last run passed
- ERR_CODE  out  2  bit0 count mismatch, bit1 bypass mismatch

## Operation
- FSM states: IDLE, HOLD_RST, RUN, CHECK_CNT, CHECK_BYP, FIN.
- All outputs are registered Moore outputs. Each takes its state's value on the edge that enters that state.
- Per-state outputs (DUT_RST_B / SELECT_3 / EN_G):
  - IDLE 0/0/0
  - HOLD_RST 0/1/0
  - RUN 1/1/1
  - CHECK_CNT 1/1/0
  - CHECK_BYP 1/0/0
  - FIN 0/0/0
- BYPASS is loaded with the captured pattern on entering CHECK_BYP. It holds that value otherwise.
- BUSY = 1 in HOLD_RST, RUN, CHECK_CNT and CHECK_BYP. DONE = 1 only in FIN.
- IDLE→HOLD_RST when START = 1. On that edge:
  - capture L = max(RUN_LEN,1) and BYPASS_PAT;
  - clear ERR_CODE and PASS.
- HOLD_RST lasts RST_CYCLES cycles, then → RUN.
- RUN lasts exactly L cycles, counted by an internal RUN_W-bit counter, then → CHECK_CNT.
- CHECK_CNT lasts 1 cycle.
  - The expected value is L[WIDTH-1:0], i.e. the L DUT increments wrap modulo 2^WIDTH.
  - On the exit edge, ERR_CODE[0] is set if CNTR_IN ≠ expected.
  - → CHECK_BYP.
- CHECK_BYP lasts 1 cycle. On the exit edge, ERR_CODE[1] is set if MUX_IN ≠ captured pattern. → FIN.
- FIN lasts 1 cycle. PASS is set to (ERR_CODE == 0) on entry and held until the next START accept. → IDLE.
- ABORT = 1 in any non-IDLE state:
  - → IDLE on the next edge;
  - no DONE pulse;
  - PASS = 0, ERR_CODE = 00.
- ABORT has priority over every other transition. START while BUSY or in FIN is ignored and not queued.
- RUN_LEN and BYPASS_PAT changes after capture have no effect on the current run.

## Timing
- Reset values:
  - DUT_RST_B = 0, SELECT_3 = 0, EN_G = 0, BYPASS = 0;
  - BUSY = 0, DONE = 0, PASS = 0, ERR_CODE = 00;
  - state IDLE, internal counters 0.
- Let the START accept be edge s. Then:
  - HOLD_RST occupies s..s+RST_CYCLES;
  - RUN is entered at s+RST_CYCLES;
  - CHECK_CNT is entered at s+RST_CYCLES+L;
  - CHECK_BYP is entered at s+RST_CYCLES+L+1;
  - FIN (DONE = 1) is entered at s+RST_CYCLES+L+2;
  - IDLE is re-entered at s+RST_CYCLES+L+3.
- BUSY falls on the edge DONE rises. A new START may be sampled the cycle after FIN.
- The DUT counter is 0 on RUN entry and increments on each of the L RUN edges. The sequencer compares CNTR_IN combinationally during the CHECK_CNT cycle, when it is L mod 2^WIDTH.
- MUX_IN is compared during the CHECK_BYP cycle, when SELECT_3 = 0 and BYPASS are already stable.
- L = 2^RUN_W − 1 is legal. The internal counter must not overflow.
- Asserting RST_B mid-run returns to the reset values immediately, with no DONE.

## Test plan
- Normal pass (WIDTH = 3, RST_CYCLES = 2): RUN_LEN = 5, BYPASS_PAT = 3'b101, model block attached, START pulse.
  - DONE at s+9;
  - PASS = 1, ERR_CODE = 00;
  - EN_G high exactly 5 cycles.
- Wrap-around: RUN_LEN = 11 → expected count 3. Correct model gives PASS = 1. Forcing CNTR_IN = 4 gives ERR_CODE = 01, PASS = 0.
- Bypass fault: RUN_LEN = 4, BYPASS_PAT = 3'b010, MUX_IN stuck at 3'b000 → ERR_CODE = 10, DONE at s+8.
- RUN_LEN = 0 → runs as L = 1: EN_G high 1 cycle, DONE at s+5, PASS = 1.
- ABORT during RUN (3rd cycle) → IDLE next edge:
  - DUT_RST_B = 0, BUSY = 0, no DONE;
  - PASS = 0, ERR_CODE = 00;
  - a START held high throughout is accepted only once back in IDLE.
- RST_B low mid-CHECK_CNT → all outputs at their reset values asynchronously. After release, START runs a fresh sequence with correct timing.
